// File: rtl/input_unit_pkg.sv
// Shared router input-port types: flit layout, output-port indices, XY route helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package input_unit_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;

  // Output-port request vector: LOCAL is the MSB, WEST the LSB.
  localparam int M       = 5;
  localparam int P_LOCAL = 4;
  localparam int P_NORTH = 3;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 1;
  localparam int P_WEST  = 0;

  typedef struct packed {
    logic                 head;
    logic                 tail;
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Wormhole lock: BUSY holds the route of the packet currently streaming.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  function automatic logic [M-1:0] xy_route(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] x_loc,
    input logic [COORD_W-1:0] y_loc
  );
    logic [M-1:0] r;
    r = '0;
    if (dest_x > x_loc)      r[P_EAST]  = 1'b1;
    else if (dest_x < x_loc) r[P_WEST]  = 1'b1;
    else if (dest_y > y_loc) r[P_SOUTH] = 1'b1;
    else if (dest_y < y_loc) r[P_NORTH] = 1'b1;
    else                     r[P_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/input_unit_fifo_buffer.sv
// Circular flit buffer with registered pointers and occupancy count.
// Latency: a pushed flit is visible at head_dat one cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; no internal guard.
module fifo_buffer
  import input_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  flit_t                  push_dat,
  input  logic                   pop,
  output flit_t                  head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  flit_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  // Next-state pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is deliberately left unreset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/input_unit.sv
// Router input port: flit FIFO, XY route computation and wormhole route lock.
// Latency: flit written at t is at o_data / o_output_req from t+1 (no bypass).
// Backpressure: o_en deasserts when the FIFO is full; head pops only on i_grant.
module input_unit
  import input_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  flit_t        i_data,
  input  logic         i_data_val,
  output logic         o_en,
  input  logic         i_grant,
  output logic [M-1:0] o_output_req,
  output flit_t        o_data,
  output logic         o_error
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_LOC);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_LOC);

  flit_t           head_flit;
  logic [CW-1:0]   count;
  logic            empty;
  logic            push;
  logic            pop;
  logic            discard;
  logic [M-1:0]    req;

  state_t          state_q, state_d;
  logic [M-1:0]    route_q, route_d;
  logic            error_q, error_d;

  assign o_en = (count < CW'(DEPTH));
  assign push = ce && i_data_val && o_en;

  fifo_buffer #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (i_data),
    .pop      (pop),
    .head_dat (head_flit),
    .count    (count),
    .empty    (empty)
  );

  // Request generation, discard of stray body flits, and next FSM/route/error state.
  always_comb begin
    req     = '0;
    discard = 1'b0;
    if (!empty) begin
      if (state_q == BUSY)     req     = route_q;
      else if (head_flit.head) req     = xy_route(head_flit.dest_x, head_flit.dest_y, X_C, Y_C);
      else                     discard = 1'b1;
    end

    // A non-head flit at the front while unlocked has no route: drop it without a grant.
    pop = ce && !empty && (i_grant || discard);

    state_d = state_q;
    route_d = route_q;
    error_d = error_q;
    if (pop) begin
      if (state_q == IDLE) begin
        if (!head_flit.head) begin
          error_d = 1'b1;
        end else if (!head_flit.tail) begin
          state_d = BUSY;
          route_d = req;
        end
      end else if (head_flit.tail) begin
        state_d = IDLE;
      end
    end
  end

  // Wormhole FSM, latched route and sticky error; everything holds when pop is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      route_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      error_q <= error_d;
    end
  end

  assign o_output_req = req;
  assign o_data       = head_flit;
  assign o_error      = error_q;

endmodule

// File: tb/tb_input_unit.sv
module tb_input_unit;
  import input_unit_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         ce;
  flit_t        i_data;
  logic         i_data_val;
  logic         o_en;
  logic         i_grant;
  logic [M-1:0] o_output_req;
  flit_t        o_data;
  logic         o_error;

  int tests = 0;
  int fails = 0;

  input_unit #(.DEPTH(4), .X_LOC(1), .Y_LOC(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce           (ce),
    .i_data       (i_data),
    .i_data_val   (i_data_val),
    .o_en         (o_en),
    .i_grant      (i_grant),
    .o_output_req (o_output_req),
    .o_data       (o_data),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ce;
    logic         vld;
    flit_t        dat;
    logic         gnt;
    logic         en;
    logic [M-1:0] req;
    logic         err;
    logic [2:0]   cnt;
    logic         busy;
    logic         chkd;
    logic [15:0]  pl;
  } vec_t;

  vec_t vq[$];

  function automatic flit_t f(input logic h, input logic t, input logic [3:0] dx,
                              input logic [3:0] dy, input logic [15:0] pl);
    flit_t x;
    x.head = h; x.tail = t; x.dest_x = dx; x.dest_y = dy; x.payload = pl;
    return x;
  endfunction

  function automatic vec_t v(input logic c, input logic vl, input flit_t d, input logic g,
                             input logic en, input logic [M-1:0] rq, input logic er,
                             input logic [2:0] cn, input logic bz, input logic cd,
                             input logic [15:0] pl);
    vec_t r;
    r.ce = c; r.vld = vl; r.dat = d; r.gnt = g; r.en = en; r.req = rq; r.err = er;
    r.cnt = cn; r.busy = bz; r.chkd = cd; r.pl = pl;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int idx, input logic en, input logic [M-1:0] rq,
                           input logic er, input logic [2:0] cn, input logic bz);
    chk({tag, "_en"},   idx, 32'(o_en), 32'(en));
    chk({tag, "_req"},  idx, 32'(o_output_req), 32'(rq));
    chk({tag, "_err"},  idx, 32'(o_error), 32'(er));
    chk({tag, "_cnt"},  idx, 32'(dut.u_fifo.count_q), 32'(cn));
    chk({tag, "_busy"}, idx, 32'(dut.state_q == BUSY), 32'(bz));
  endtask

  initial begin
    flit_t z;
    z = '0;
    reset_n = 1'b0; ce = 1'b1; i_data = '0; i_data_val = 1'b0; i_grant = 1'b0;
    #12;
    chk_state("reset", 0, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0);
    @(negedge clk) reset_n = 1'b1;

    // Single head+tail flit to self, then a 3-flit packet routed EAST.
    vq.push_back(v(1,1,f(1,1,1,1,16'hA001),0, 1,5'b10000,0,3'd1,0, 1,16'hA001));
    vq.push_back(v(1,0,z,1,                   1,5'b00000,0,3'd0,0, 0,16'h0));
    vq.push_back(v(1,1,f(1,0,3,1,16'hA010),0, 1,5'b00100,0,3'd1,0, 1,16'hA010));
    vq.push_back(v(1,1,f(0,0,0,3,16'hA011),1, 1,5'b00100,0,3'd1,1, 1,16'hA011));
    vq.push_back(v(1,1,f(0,1,0,0,16'hA012),1, 1,5'b00100,0,3'd1,1, 1,16'hA012));
    vq.push_back(v(1,0,z,1,                   1,5'b00000,0,3'd0,0, 0,16'h0));
    // WEST, NORTH, SOUTH single-flit packets with overlapping write+pop.
    vq.push_back(v(1,1,f(1,1,0,1,16'hA020),0, 1,5'b00001,0,3'd1,0, 1,16'hA020));
    vq.push_back(v(1,1,f(1,1,1,0,16'hA021),1, 1,5'b01000,0,3'd1,0, 1,16'hA021));
    vq.push_back(v(1,1,f(1,1,1,2,16'hA022),1, 1,5'b00010,0,3'd1,0, 1,16'hA022));
    vq.push_back(v(1,0,z,1,                   1,5'b00000,0,3'd0,0, 0,16'h0));
    // Fill to full, blocked write, then simultaneous write+pop, then drain.
    vq.push_back(v(1,1,f(1,0,2,1,16'hB000),0, 1,5'b00100,0,3'd1,0, 1,16'hB000));
    vq.push_back(v(1,1,f(0,0,0,0,16'hB001),0, 1,5'b00100,0,3'd2,0, 1,16'hB000));
    vq.push_back(v(1,1,f(0,0,0,0,16'hB002),0, 1,5'b00100,0,3'd3,0, 1,16'hB000));
    vq.push_back(v(1,1,f(0,0,0,0,16'hB003),0, 0,5'b00100,0,3'd4,0, 1,16'hB000));
    vq.push_back(v(1,1,f(0,1,0,0,16'hBEEF),1, 1,5'b00100,0,3'd3,1, 1,16'hB001));
    vq.push_back(v(1,1,f(0,1,0,0,16'hB004),1, 1,5'b00100,0,3'd3,1, 1,16'hB002));
    vq.push_back(v(1,0,z,1,                   1,5'b00100,0,3'd2,1, 1,16'hB003));
    vq.push_back(v(1,0,z,1,                   1,5'b00100,0,3'd1,1, 1,16'hB004));
    vq.push_back(v(1,0,z,1,                   1,5'b00000,0,3'd0,0, 0,16'h0));
    // Stray body flit while idle: discarded without grant, sticky error.
    vq.push_back(v(1,1,f(0,0,2,2,16'hC000),0, 1,5'b00000,0,3'd1,0, 1,16'hC000));
    vq.push_back(v(1,0,z,0,                   1,5'b00000,1,3'd0,0, 0,16'h0));
    vq.push_back(v(1,1,f(1,1,1,1,16'hC001),0, 1,5'b10000,1,3'd1,0, 1,16'hC001));
    vq.push_back(v(1,0,z,1,                   1,5'b00000,1,3'd0,0, 0,16'h0));
    // Clock enable low freezes a pending grant and write; both land once ce returns.
    vq.push_back(v(1,1,f(1,0,3,1,16'hD000),0, 1,5'b00100,1,3'd1,0, 1,16'hD000));
    vq.push_back(v(0,1,f(0,1,0,0,16'hD001),1, 1,5'b00100,1,3'd1,0, 1,16'hD000));
    vq.push_back(v(1,1,f(0,1,0,0,16'hD001),1, 1,5'b00100,1,3'd1,1, 1,16'hD001));
    vq.push_back(v(1,0,z,1,                   1,5'b00000,1,3'd0,0, 0,16'h0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      ce = vq[i].ce; i_data_val = vq[i].vld; i_data = vq[i].dat; i_grant = vq[i].gnt;
      @(posedge clk);
      #1;
      chk_state("vec", i, vq[i].en, vq[i].req, vq[i].err, vq[i].cnt, vq[i].busy);
      if (vq[i].chkd) chk("vec_data", i, 32'(o_data.payload), 32'(vq[i].pl));
    end

    // No bypass: a flit being written is not visible before the capturing edge.
    @(negedge clk);
    ce = 1'b1; i_data_val = 1'b1; i_data = f(1,1,0,1,16'hE000); i_grant = 1'b0;
    #1;
    chk("nobypass_req", 0, 32'(o_output_req), 32'h0);
    @(posedge clk); #1;
    chk("nobypass_req", 1, 32'(o_output_req), 32'h01);
    @(negedge clk);
    i_data_val = 1'b0; i_grant = 1'b1;
    @(posedge clk); #1;
    chk("nobypass_cnt", 2, 32'(dut.u_fifo.count_q), 32'h0);

    // Reset mid-packet with two flits buffered and the route locked.
    @(negedge clk);
    i_data_val = 1'b1; i_data = f(1,0,3,1,16'hF000); i_grant = 1'b0;
    @(negedge clk);
    i_data = f(0,0,0,0,16'hF001); i_grant = 1'b1;
    @(negedge clk);
    i_data = f(0,0,0,0,16'hF002); i_grant = 1'b0;
    @(negedge clk);
    i_data_val = 1'b0;
    chk_state("premid", 0, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_state("midrst", 0, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    // Route lock must be gone: a fresh single-flit packet routes on its own header.
    @(negedge clk);
    i_data_val = 1'b1; i_data = f(1,1,1,2,16'hF010);
    @(posedge clk); #1;
    chk_state("postrst", 1, 1'b1, 5'b00010, 1'b0, 3'd1, 1'b0);
    chk("postrst_data", 1, 32'(o_data.payload), 32'hF010);
    @(negedge clk);
    i_data_val = 1'b0; i_grant = 1'b1;
    @(posedge clk); #1;
    chk_state("postrst", 2, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
